// File: rtl/ttl74x161_chain_pkg.sv
// rtl/ttl74x161_chain_pkg.sv - shared nibble constants for 74x161-style counter parts
package ttl74x161_chain_pkg;

  localparam int              NIBBLE_W   = 4;
  localparam logic [NIBBLE_W-1:0] NIBBLE_MAX = 4'hF;

  function automatic logic nibble_full(input logic [NIBBLE_W-1:0] v);
    return v == NIBBLE_MAX;
  endfunction

endpackage

// File: rtl/ttl74x161.sv
// rtl/ttl74x161.sv - single 74x161 synchronous 4-bit binary counter
module ttl74x161
  import ttl74x161_chain_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load_n,
  input  logic                enp,
  input  logic                ent,
  input  logic [NIBBLE_W-1:0] d,
  output logic [NIBBLE_W-1:0] q,
  output logic                rco
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (!load_n) begin
      q <= d;
    end else if (enp && ent) begin
      q <= q + 1'b1;
    end
  end

  // enp deliberately does not gate the carry, as on the real chip
  assign rco = ent & nibble_full(q);

endmodule

// File: rtl/ttl74x161_chain.sv
// rtl/ttl74x161_chain.sv - ripple-carry cascade of 74x161 counters feeding the '153 selects
module ttl74x161_chain
  import ttl74x161_chain_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       load_n,
  input  logic                       enp,
  input  logic                       ent,
  input  logic [NIBBLE_W*STAGES-1:0] d,
  output logic [NIBBLE_W*STAGES-1:0] q,
  output logic                       rco,
  output logic                       sel_a,
  output logic                       sel_b
);

  // carry[i] is the ent of stage i; carry[STAGES] leaves the chain
  logic [STAGES:0] carry;

  assign carry[0] = ent;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    ttl74x161 u_chip (
      .clk     (clk),
      .reset_n (reset_n),
      .load_n  (load_n),
      .enp     (enp),
      .ent     (carry[i]),
      .d       (d[i*NIBBLE_W +: NIBBLE_W]),
      .q       (q[i*NIBBLE_W +: NIBBLE_W]),
      .rco     (carry[i+1])
    );
  end

  assign rco   = carry[STAGES];
  assign sel_a = q[0];
  assign sel_b = q[1];

endmodule

// File: tb/tb_ttl74x161_chain.sv
// tb/tb_ttl74x161_chain.sv - directed bench for the counter chain with integer reference model
module tb_ttl74x161_chain;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       load_n;
  logic       enp;
  logic       ent;
  logic [7:0] d;
  logic [7:0] q;
  logic       rco, sel_a, sel_b;
  logic [3:0] q1;
  logic       rco1, sel_a1, sel_b1;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 1'b0;

  int m2 = 0;
  int m1 = 0;

  always #5 clk = ~clk;

  ttl74x161_chain #(.STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .load_n(load_n), .enp(enp), .ent(ent),
    .d(d), .q(q), .rco(rco), .sel_a(sel_a), .sel_b(sel_b)
  );

  ttl74x161_chain #(.STAGES(1)) u_one (
    .clk(clk), .reset_n(reset_n), .load_n(load_n), .enp(enp), .ent(ent),
    .d(d[3:0]), .q(q1), .rco(rco1), .sel_a(sel_a1), .sel_b(sel_b1)
  );

  // Whole-number model: each chain is one binary counter of its total width
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m2 <= 0;
      m1 <= 0;
    end else if (!load_n) begin
      m2 <= int'(d);
      m1 <= int'(d[3:0]);
    end else if (enp && ent) begin
      m2 <= (m2 + 1) % 256;
      m1 <= (m1 + 1) % 16;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_q",     int'(q),     m2);
      chk("model_rco",   int'(rco),   int'(ent && m2 == 255));
      chk("model_sel",   int'({sel_b, sel_a}), m2 % 4);
      chk("model_q1",    int'(q1),    m1);
      chk("model_rco1",  int'(rco1),  int'(ent && m1 == 15));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int sel_exp [4] = '{0, 1, 2, 3};
    int t3_exp  [3] = '{8'h0F, 8'h10, 8'h11};

    reset_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d = 8'h00;
    repeat (2) step();
    chk("reset_q", int'(q), 0);
    reset_n = 1'b1;
    started = 1'b1;

    // T1: asynchronous clear mid-count
    d = 8'h5A; load_n = 1'b0; step(); load_n = 1'b1;
    chk("t1_load", int'(q), 8'h5A);
    #1 reset_n = 1'b0;
    #1 chk("t1_async_q", int'(q), 0);
    chk("t1_sel", int'({sel_b, sel_a}), 0);
    step(); reset_n = 1'b1;

    // T2: load beats count, then select stepping
    d = 8'hA7; load_n = 1'b0; enp = 1'b1; ent = 1'b1;
    step();
    chk("t2_load", int'(q), 8'hA7);
    load_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_count", int'(q), 8'hA8 + i);
      chk("t2_sel", int'({sel_b, sel_a}), sel_exp[i]);
    end

    // T3: nibble carry
    d = 8'h0E; load_n = 1'b0; step(); load_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_q", int'(q), t3_exp[i]);
      if (i == 0) begin
        chk("t3_stage0_rco", int'(u_dut.carry[1]), 1);
        chk("t3_chain_rco", int'(rco), 0);
      end
    end

    // T4: full wrap, then ent=0 at all-ones
    d = 8'hFF; load_n = 1'b0; step(); load_n = 1'b1;
    chk("t4_rco_hi", int'(rco), 1);
    step();
    chk("t4_wrap", int'(q), 0);
    chk("t4_rco_lo", int'(rco), 0);
    load_n = 1'b0; step(); load_n = 1'b1; ent = 1'b0;
    #1 chk("t4_ent0_rco", int'(rco), 0);
    step();
    chk("t4_ent0_hold", int'(q), 8'hFF);

    // T5: enp low holds all-ones with rco still asserted
    ent = 1'b1; enp = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_hold", int'(q), 8'hFF);
      chk("t5_rco", int'(rco), 1);
    end
    enp = 1'b1; step();
    chk("t5_wrap", int'(q), 0);

    // Load wins over wrap at all-ones
    d = 8'hFF; load_n = 1'b0; step();
    d = 8'h42; step(); load_n = 1'b1;
    chk("load_over_wrap", int'(q), 8'h42);

    // T6: reset released while load_n is low
    reset_n = 1'b0; load_n = 1'b0; d = 8'h3C;
    step();
    chk("t6_in_reset", int'(q), 0);
    @(negedge clk); #1 reset_n = 1'b1;
    #1 chk("t6_released", int'(q), 0);
    step();
    chk("t6_load", int'(q), 8'h3C);

    // Single-stage chain
    d = 8'h0F; load_n = 1'b0; step(); load_n = 1'b1; enp = 1'b1; ent = 1'b1;
    chk("one_q", int'(q1), 4'hF);
    chk("one_rco", int'(rco1), 1);
    step();
    chk("one_wrap", int'(q1), 0);
    chk("one_rco_lo", int'(rco1), 0);

    step();
    started = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
